// File: rtl/mem_stage_if.sv
// mem_stage_if: signal bundle around the memory-access stage.
//   EX side     : ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3,
//                 ex_rd, ex_alu_result, ex_store_data (into the stage),
//                 mem_stall (out of the stage)
//   dmem side   : dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata (out),
//                 dmem_ready, dmem_rdata (in)
//   WB side     : wb_valid, wb_reg_write, wb_funct3, wb_rd, wb_mem_out,
//                 wb_rd_data, misalign_exc (out)
//   debug       : dbg_state (1 = ACCESS, 0 = IDLE)
//
// Handshakes: an EX instruction transfers on a clock edge where
// ex_valid=1 and mem_stall=0. A dmem request is raised with dmem_req=1 and its
// address/we/be/wdata stay stable until the edge where dmem_ready=1, which
// completes it; dmem_rdata is only meaningful on that edge.
// Modport slave is the stage itself; master is its environment.
interface mem_stage_if #(
   parameter int XLEN = 32
);
   logic            ex_valid;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_reg_write;
   logic [2:0]      ex_funct3;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_alu_result;
   logic [XLEN-1:0] ex_store_data;
   logic            mem_stall;

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;

   logic            wb_valid;
   logic            wb_reg_write;
   logic [2:0]      wb_funct3;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_mem_out;
   logic [XLEN-1:0] wb_rd_data;
   logic            misalign_exc;

   logic            dbg_state;

   modport slave (
      input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3,
             ex_rd, ex_alu_result, ex_store_data, dmem_ready, dmem_rdata,
      output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_valid, wb_reg_write, wb_funct3, wb_rd, wb_mem_out, wb_rd_data,
             misalign_exc, dbg_state
   );

   modport master (
      output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3,
             ex_rd, ex_alu_result, ex_store_data, dmem_ready, dmem_rdata,
      input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
             wb_valid, wb_reg_write, wb_funct3, wb_rd, wb_mem_out, wb_rd_data,
             misalign_exc, dbg_state
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with the MEM/WB pipeline register.
// Ports:
//   clk  - pipeline clock
//   rst  - synchronous active-high reset
//   bus  - mem_stage_if.slave: EX inputs + mem_stall, data-memory req/ready
//          port, MEM/WB outputs, misalign_exc pulse, dbg_state.
// Non-memory instructions retire one cycle after consumption. Aligned loads
// and stores go to ACCESS and wait for dmem_ready; misaligned ones raise a
// one-cycle misalign_exc and never touch memory.
module mem_stage #(
   parameter int XLEN     = 32,
   parameter int ADDR_LSB = 2
) (
   input logic       clk,
   input logic       rst,
   mem_stage_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t          state_q;
   logic            is_load_q;
   logic            reg_write_q;
   logic [2:0]      funct3_q;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] addr_q;

   logic            dmem_req_q;
   logic            dmem_we_q;
   logic [XLEN-1:0] dmem_addr_q;
   logic [3:0]      dmem_be_q;
   logic [XLEN-1:0] dmem_wdata_q;
   logic            wb_valid_q;
   logic            wb_reg_write_q;
   logic [2:0]      wb_funct3_q;
   logic [4:0]      wb_rd_q;
   logic [XLEN-1:0] wb_mem_out_q;
   logic [XLEN-1:0] wb_rd_data_q;
   logic            misalign_q;

   logic            is_mem_d;
   logic            is_load_d;
   logic            misalign_d;
   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d;
   logic [1:0]      off_d;

   // A read+write combination is treated as a load.
   assign is_mem_d  = bus.ex_mem_read | bus.ex_mem_write;
   assign is_load_d = bus.ex_mem_read;
   assign off_d     = bus.ex_alu_result[1:0];

   always_comb begin
      misalign_d = 1'b0;
      be_d       = 4'b1111;
      wdata_d    = '0;
      case (bus.ex_funct3[1:0])
         2'b01:   misalign_d = off_d[0];
         2'b10:   misalign_d = |off_d;
         default: misalign_d = 1'b0;
      endcase
      // Store data is replicated across lanes so any lane the byte enables
      // select already carries the right bytes.
      if (!is_load_d) begin
         case (bus.ex_funct3[1:0])
            2'b00: begin
               be_d    = 4'b0001 << off_d;
               wdata_d = {4{bus.ex_store_data[7:0]}};
            end
            2'b01: begin
               be_d    = off_d[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{bus.ex_store_data[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = bus.ex_store_data;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         is_load_q      <= 1'b0;
         reg_write_q    <= 1'b0;
         funct3_q       <= '0;
         rd_q           <= '0;
         addr_q         <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_be_q      <= '0;
         dmem_wdata_q   <= '0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_funct3_q    <= '0;
         wb_rd_q        <= '0;
         wb_mem_out_q   <= '0;
         wb_rd_data_q   <= '0;
         misalign_q     <= 1'b0;
      end else begin
         // Retirement and exception are single-cycle pulses by default.
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         misalign_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.ex_valid) begin
                  if (!is_mem_d) begin
                     wb_valid_q     <= 1'b1;
                     wb_reg_write_q <= bus.ex_reg_write & (bus.ex_rd != 5'd0);
                     wb_funct3_q    <= bus.ex_funct3;
                     wb_rd_q        <= bus.ex_rd;
                     wb_rd_data_q   <= bus.ex_alu_result;
                     wb_mem_out_q   <= '0;
                  end else if (misalign_d) begin
                     misalign_q <= 1'b1;
                  end else begin
                     state_q      <= ACCESS;
                     is_load_q    <= is_load_d;
                     reg_write_q  <= bus.ex_reg_write;
                     funct3_q     <= bus.ex_funct3;
                     rd_q         <= bus.ex_rd;
                     addr_q       <= bus.ex_alu_result;
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= ~is_load_d;
                     dmem_addr_q  <= {bus.ex_alu_result[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
                     dmem_be_q    <= be_d;
                     dmem_wdata_q <= wdata_d;
                  end
               end
            end
            ACCESS: begin
               // Request fields are simply not touched while waiting, so they
               // stay stable until the completing edge.
               if (bus.dmem_ready) begin
                  state_q        <= IDLE;
                  dmem_req_q     <= 1'b0;
                  wb_valid_q     <= 1'b1;
                  wb_funct3_q    <= funct3_q;
                  wb_rd_q        <= rd_q;
                  wb_rd_data_q   <= addr_q;
                  wb_reg_write_q <= is_load_q & reg_write_q & (rd_q != 5'd0);
                  // Addressed byte lands at [7:0]; sign/zero extension is WB's job.
                  wb_mem_out_q   <= is_load_q ? (bus.dmem_rdata >> {addr_q[1:0], 3'b000}) : '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_stall    = (state_q == ACCESS);
   assign bus.dbg_state    = (state_q == ACCESS);
   assign bus.dmem_req     = dmem_req_q;
   assign bus.dmem_we      = dmem_we_q;
   assign bus.dmem_addr    = dmem_addr_q;
   assign bus.dmem_be      = dmem_be_q;
   assign bus.dmem_wdata   = dmem_wdata_q;
   assign bus.wb_valid     = wb_valid_q;
   assign bus.wb_reg_write = wb_reg_write_q;
   assign bus.wb_funct3    = wb_funct3_q;
   assign bus.wb_rd        = wb_rd_q;
   assign bus.wb_mem_out   = wb_mem_out_q;
   assign bus.wb_rd_data   = wb_rd_data_q;
   assign bus.misalign_exc = misalign_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage RV32I pipeline. It sits between the EX/MEM boundary and the writeback stage. It consumes ALU results and store data from EX and runs load/store transactions on a data-memory port that uses a req/ready handshake with variable latency. It owns the MEM/WB pipeline register, presenting funct3, rd, the lane-aligned load word and the ALU result to writeback.

Parameters:
XLEN, 32, datapath and address width
ADDR_LSB, 2, byte-offset bits within a word (fixed for 32-bit words)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX presents an instruction
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_reg_write  in  1  instruction writes rd
ex_funct3  in  3  load/store size and sign code
ex_rd  in  5  destination register
ex_alu_result  in  32  ALU result, or effective address for load/store
ex_store_data  in  32  rs2 value for stores
mem_stall  out  1  EX must hold its current instruction
dmem_req  out  1  memory request
dmem_we  out  1  request is a write
dmem_addr  out  32  word-aligned address
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ready  in  1  memory completes the request this cycle
dmem_rdata  in  32  read word, valid when dmem_ready=1
wb_valid  out  1  MEM/WB register holds a retiring instruction
wb_reg_write  out  1  writeback enable
wb_funct3  out  3  forwarded funct3
wb_rd  out  5  forwarded rd
wb_mem_out  out  32  load word shifted so the addressed byte is at [7:0]
wb_rd_data  out  32  forwarded ALU result
misalign_exc  out  1  one-cycle misaligned-access pulse

Behaviour:
- Reset: on the clk edge with rst=1:
  - state goes to IDLE;
  - all outputs go to 0, including dmem_req, wb_valid and misalign_exc;
  - any outstanding access is abandoned, and a later dmem_ready is ignored.
- FSM states: IDLE and ACCESS.
- mem_stall = (state==ACCESS). An EX instruction is consumed on an edge with ex_valid=1 and mem_stall=0.
- Memory-op priority: if ex_mem_read and ex_mem_write are both 1, the instruction is treated as a load.
- Non-memory instruction consumed (IDLE):
  - next cycle wb_valid=1;
  - wb_rd_data=ex_alu_result, wb_rd and wb_funct3 forwarded, wb_mem_out=0;
  - wb_reg_write = ex_reg_write AND (ex_rd != 0);
  - latency is 1 cycle and state stays IDLE.
- Misalignment check, for loads and stores:
  - halfword sizes (funct3[1:0]=01) with addr[0]=1 are misaligned;
  - word size (10) with addr[1:0]!=0 is misaligned;
  - on a misaligned access: no dmem_req, misalign_exc=1 for exactly one cycle, wb_valid=0, state stays IDLE.
- Aligned memory instruction consumed (IDLE):
  - the instruction is captured and state goes to ACCESS;
  - next cycle wb_valid=0 (bubble) and dmem_req=1.
- Request signals during ACCESS:
  - dmem_addr = {addr[31:2],2'b00};
  - dmem_we=1 for stores, 0 for loads.
- Store byte enables and data:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}};
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}};
  - SW: be = 4'b1111, wdata = data;
  - loads: be = 4'b1111.
- ACCESS hold: dmem_req, addr, we, be and wdata are held stable every cycle until an edge samples dmem_ready=1. While waiting, wb_valid=0.
- Completion edge (ACCESS and dmem_ready=1):
  - state goes to IDLE and dmem_req=0 next cycle;
  - wb_valid=1 and wb_rd_data=captured address;
  - load: wb_mem_out = dmem_rdata >> (8*addr[1:0]), wb_reg_write = captured reg_write AND rd!=0;
  - store: wb_mem_out=0, wb_reg_write=0.
- Load latency: with dmem_ready in the first ACCESS cycle, the load retires 2 cycles after consumption, and each wait cycle adds one.
- Back-to-back: because mem_stall stays 1 through the completion cycle, the next EX instruction is consumed on the first IDLE cycle after completion.
- In IDLE, dmem_ready and dmem_rdata are ignored.
- Outside retirement cycles, wb_valid=0 and wb_reg_write=0.

Test Plan:
- Reset mid-ACCESS: load in flight, rst=1 one cycle → next cycle dmem_req=0, wb_valid=0, state IDLE; dmem_ready=1 the cycle after has no effect.
- ADD, rd=5, result 0x1234 → next cycle wb_valid=1, wb_reg_write=1, wb_rd=5, wb_rd_data=0x1234, mem_stall=0 throughout.
- Same with rd=0 → wb_valid=1, wb_reg_write=0.
- LBU at addr 0x103, dmem_ready after 3 wait cycles, rdata=0xAABBCCDD:
  - dmem_addr=0x100, be=1111;
  - mem_stall high 4 cycles;
  - wb_mem_out=0x000000AA.
- SH at 0x202, data 0x0000BEEF, ready immediately → dmem_we=1, be=1100, wdata=0xBEEFBEEF; wb_valid=1 with wb_reg_write=0.
- LW at 0x301 → misalign_exc pulses one cycle, no dmem_req, wb_valid=0. A following ADD is consumed next cycle.
